// File: rtl/fifo2stream_burst.sv
// rtl/fifo2stream_burst.sv - FWFT FIFO to fixed-length burst stream adapter
// Optional feature macro FIFO2STREAM_PAD_EN: pad a starved burst with PAD_VALUE beats.
module fifo2stream_burst #(
  parameter int                    DATA_WIDTH   = 4,
  parameter int                    BURST_LEN    = 16,
  parameter int                    IDLE_TIMEOUT = 8,
  parameter logic [DATA_WIDTH-1:0] PAD_VALUE    = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] fifo_dout,
  input  logic                  fifo_empty,
  output logic                  fifo_rd_en,
  output logic [DATA_WIDTH-1:0] m_tdata,
  output logic                  m_tvalid,
  input  logic                  m_tready,
  output logic                  m_tlast,
  output logic                  m_tuser
);

  localparam int               CNT_W     = $clog2(BURST_LEN);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);

  if (DATA_WIDTH < 1 || BURST_LEN < 2 || IDLE_TIMEOUT < 1 ||
      $bits(PAD_VALUE) != DATA_WIDTH) begin : g_param_check
    $error("fifo2stream_burst: invalid parameter set");
  end

`ifdef FIFO2STREAM_PAD_EN
  typedef enum logic [1:0] {IDLE, ACTIVE, PAD} state_t;

  localparam int                  STARVE_W   = $clog2(IDLE_TIMEOUT + 1);
  localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(IDLE_TIMEOUT);

  logic [STARVE_W-1:0] starve_cnt;
  logic [STARVE_W-1:0] starve_cnt_nxt;
  logic                m_tuser_nxt;
`else
  typedef enum logic {IDLE, ACTIVE} state_t;
`endif

  state_t                state;
  state_t                state_nxt;
  logic [CNT_W-1:0]      beat_cnt;
  logic [CNT_W-1:0]      beat_cnt_nxt;
  logic [DATA_WIDTH-1:0] m_tdata_nxt;
  logic                  m_tvalid_nxt;
  logic                  m_tlast_nxt;
  logic                  load_ok;
  logic                  in_pad;
  logic                  pop;
  logic                  at_last;

  // The single output register may load whenever it is empty or being drained.
  assign load_ok = ~m_tvalid | m_tready;

`ifdef FIFO2STREAM_PAD_EN
  assign in_pad = (state == PAD);
`else
  assign in_pad  = 1'b0;
  assign m_tuser = 1'b0;
`endif

  // Gated by rst_n so no word is lost from the FIFO while the block is held in reset.
  assign pop        = rst_n & ~fifo_empty & load_ok & ~in_pad;
  assign fifo_rd_en = pop;
  assign at_last    = (beat_cnt == LAST_BEAT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      beat_cnt   <= '0;
      m_tdata    <= '0;
      m_tvalid   <= 1'b0;
      m_tlast    <= 1'b0;
`ifdef FIFO2STREAM_PAD_EN
      m_tuser    <= 1'b0;
      starve_cnt <= '0;
`endif
    end else begin
      state      <= state_nxt;
      beat_cnt   <= beat_cnt_nxt;
      m_tdata    <= m_tdata_nxt;
      m_tvalid   <= m_tvalid_nxt;
      m_tlast    <= m_tlast_nxt;
`ifdef FIFO2STREAM_PAD_EN
      m_tuser    <= m_tuser_nxt;
      starve_cnt <= starve_cnt_nxt;
`endif
    end
  end

  always_comb begin
    state_nxt      = state;
    beat_cnt_nxt   = beat_cnt;
    m_tdata_nxt    = m_tdata;
    m_tvalid_nxt   = m_tvalid;
    m_tlast_nxt    = m_tlast;
`ifdef FIFO2STREAM_PAD_EN
    m_tuser_nxt    = m_tuser;
    starve_cnt_nxt = starve_cnt;
`endif

    if (pop) begin
      m_tdata_nxt  = fifo_dout;
      m_tvalid_nxt = 1'b1;
      m_tlast_nxt  = at_last;
`ifdef FIFO2STREAM_PAD_EN
      m_tuser_nxt  = 1'b0;
`endif
      beat_cnt_nxt = at_last ? '0 : beat_cnt + 1'b1;
      state_nxt    = at_last ? IDLE : ACTIVE;
    end
`ifdef FIFO2STREAM_PAD_EN
    else if (in_pad && load_ok) begin
      m_tdata_nxt  = PAD_VALUE;
      m_tvalid_nxt = 1'b1;
      m_tlast_nxt  = at_last;
      m_tuser_nxt  = 1'b1;
      beat_cnt_nxt = at_last ? '0 : beat_cnt + 1'b1;
      state_nxt    = at_last ? IDLE : PAD;
    end
`endif
    else if (load_ok) begin
      m_tvalid_nxt = 1'b0;
    end

`ifdef FIFO2STREAM_PAD_EN
    // A pop on the would-be timeout cycle clears the count, so real data always beats padding.
    if (state != ACTIVE || pop) begin
      starve_cnt_nxt = '0;
    end else if (fifo_empty && load_ok && starve_cnt != STARVE_MAX) begin
      starve_cnt_nxt = starve_cnt + 1'b1;
    end

    if (state == ACTIVE && !pop && starve_cnt_nxt == STARVE_MAX) begin
      state_nxt = PAD;
    end
`endif
  end

endmodule

// File: tb/tb_fifo2stream_burst.sv
// tb/tb_fifo2stream_burst.sv - table-driven bench for fifo2stream_burst
// Pad-path sequences are built when FIFO2STREAM_PAD_EN is defined, the no-pad sequence otherwise.
module tb_fifo2stream_burst;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] fifo_dout;
  logic       fifo_empty;
  logic       fifo_rd_en;
  logic [7:0] m_tdata;
  logic       m_tvalid;
  logic       m_tready;
  logic       m_tlast;
  logic       m_tuser;

  localparam logic [7:0] PAD = 8'hE5;

  fifo2stream_burst #(
    .DATA_WIDTH  (8),
    .BURST_LEN   (4),
    .IDLE_TIMEOUT(3),
    .PAD_VALUE   (PAD)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .fifo_dout (fifo_dout),
    .fifo_empty(fifo_empty),
    .fifo_rd_en(fifo_rd_en),
    .m_tdata   (m_tdata),
    .m_tvalid  (m_tvalid),
    .m_tready  (m_tready),
    .m_tlast   (m_tlast),
    .m_tuser   (m_tuser)
  );

  always #5 clk = ~clk;

  // FWFT FIFO model
  logic [7:0] mem [0:127];
  int         rd_ptr = 0;
  int         wr_ptr = 0;

  assign fifo_empty = (rd_ptr == wr_ptr);
  assign fifo_dout  = mem[rd_ptr[6:0]];

  always @(posedge clk) begin
    if (fifo_rd_en) rd_ptr <= rd_ptr + 1;
  end

  typedef struct {
    bit         rst;
    bit         rdy;
    int         npush;
    logic [7:0] din;
    bit         e_rd;
    bit         e_v;
    logic [7:0] e_d;
    bit         e_l;
    bit         e_u;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic void add(bit rst, bit rdy, int npush, logic [7:0] din,
                              bit e_rd, bit e_v, logic [7:0] e_d, bit e_l, bit e_u);
    vec_t t;
    t.rst = rst; t.rdy = rdy; t.npush = npush; t.din = din;
    t.e_rd = e_rd; t.e_v = e_v; t.e_d = e_d; t.e_l = e_l; t.e_u = e_u;
    vecs.push_back(t);
  endfunction

  task automatic push_words(input int n, input logic [7:0] first);
    for (int k = 0; k < n; k++) begin
      mem[wr_ptr[6:0]] = first + 8'(k);
      wr_ptr++;
    end
  endtask

  task automatic run(input string name);
    logic [11:0] got;
    logic [11:0] exp;
    logic [11:0] mask;
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      rst_n    = vecs[i].rst;
      m_tready = vecs[i].rdy;
      push_words(vecs[i].npush, vecs[i].din);
      #1;
      got  = {fifo_rd_en, m_tvalid, m_tdata, m_tlast, m_tuser};
      exp  = {vecs[i].e_rd, vecs[i].e_v, vecs[i].e_d, vecs[i].e_l, vecs[i].e_u};
      mask = (vecs[i].e_v || !vecs[i].rst) ? 12'hFFF : 12'hC00;
      n_checks++;
      if ((got & mask) !== (exp & mask)) begin
        n_fail++;
        $display("FAIL %s[%0d]: got rd_en=%b tvalid=%b tdata=%h tlast=%b tuser=%b, expected rd_en=%b tvalid=%b tdata=%h tlast=%b tuser=%b",
                 name, i, fifo_rd_en, m_tvalid, m_tdata, m_tlast, m_tuser,
                 vecs[i].e_rd, vecs[i].e_v, vecs[i].e_d, vecs[i].e_l, vecs[i].e_u);
      end
    end
    vecs.delete();
  endtask

  initial begin
    rst_n    = 1'b0;
    m_tready = 1'b0;
    push_words(8, 8'h01);

    // reset holds everything at zero even with a non-empty FIFO
    add(0,0,0,0,     0,0,8'h00,0,0);
    add(0,0,0,0,     0,0,8'h00,0,0);
    run("reset");

    // full-rate burst: 1..8, tlast on 4 and 8
    add(1,1,0,0,     1,0,8'h00,0,0);
    add(1,1,0,0,     1,1,8'h01,0,0);
    add(1,1,0,0,     1,1,8'h02,0,0);
    add(1,1,0,0,     1,1,8'h03,0,0);
    add(1,1,0,0,     1,1,8'h04,1,0);
    add(1,1,0,0,     1,1,8'h05,0,0);
    add(1,1,0,0,     1,1,8'h06,0,0);
    add(1,1,0,0,     1,1,8'h07,0,0);
    add(1,1,0,0,     0,1,8'h08,1,0);
    add(1,1,0,0,     0,0,8'h00,0,0);
    run("full_rate");

    // ready toggling 1010: each word held across its stall, pops only when load_ok
    add(1,1,4,8'h21, 1,0,8'h00,0,0);
    add(1,0,0,0,     0,1,8'h21,0,0);
    add(1,1,0,0,     1,1,8'h21,0,0);
    add(1,0,0,0,     0,1,8'h22,0,0);
    add(1,1,0,0,     1,1,8'h22,0,0);
    add(1,0,0,0,     0,1,8'h23,0,0);
    add(1,1,0,0,     1,1,8'h23,0,0);
    add(1,0,0,0,     0,1,8'h24,1,0);
    add(1,1,0,0,     0,1,8'h24,1,0);
    add(1,0,0,0,     0,0,8'h00,0,0);
    run("ready_toggle");

    // reset after beat 2 of 4: held beat 0x53 is dropped, next word restarts at beat 0
    add(1,1,7,8'h51, 1,0,8'h00,0,0);
    add(1,1,0,0,     1,1,8'h51,0,0);
    add(1,1,0,0,     1,1,8'h52,0,0);
    add(0,1,0,0,     0,0,8'h00,0,0);
    add(0,1,0,0,     0,0,8'h00,0,0);
    add(1,1,0,0,     1,0,8'h00,0,0);
    add(1,1,0,0,     1,1,8'h54,0,0);
    add(1,1,0,0,     1,1,8'h55,0,0);
    add(1,1,0,0,     1,1,8'h56,0,0);
    add(1,1,0,0,     0,1,8'h57,1,0);
    add(1,1,0,0,     0,0,8'h00,0,0);
    run("reset_mid_burst");

`ifdef FIFO2STREAM_PAD_EN
    // two words, three starved cycles, then two pad beats closing the burst
    add(1,1,2,8'hA0, 1,0,8'h00,0,0);
    add(1,1,0,0,     1,1,8'hA0,0,0);
    add(1,1,0,0,     0,1,8'hA1,0,0);
    add(1,1,0,0,     0,0,8'h00,0,0);
    add(1,1,0,0,     0,0,8'h00,0,0);
    add(1,1,0,0,     0,0,8'h00,0,0);
    add(1,1,0,0,     0,1,PAD,  0,1);
    add(1,1,0,0,     0,1,PAD,  1,1);
    add(1,1,0,0,     0,0,8'h00,0,0);
    run("pad_timeout");

    // refill on the timeout cycle wins; later timeout pads once without popping in PAD
    add(1,1,2,8'hB0, 1,0,8'h00,0,0);
    add(1,1,0,0,     1,1,8'hB0,0,0);
    add(1,1,0,0,     0,1,8'hB1,0,0);
    add(1,1,0,0,     0,0,8'h00,0,0);
    add(1,1,1,8'hB2, 1,0,8'h00,0,0);
    add(1,1,0,0,     0,1,8'hB2,0,0);
    add(1,1,0,0,     0,0,8'h00,0,0);
    add(1,1,0,0,     0,0,8'h00,0,0);
    add(1,1,1,8'hD0, 0,0,8'h00,0,0);
    add(1,1,0,0,     1,1,PAD,  1,1);
    add(1,1,3,8'hD1, 1,1,8'hD0,0,0);
    add(1,1,0,0,     1,1,8'hD1,0,0);
    add(1,1,0,0,     1,1,8'hD2,0,0);
    add(1,1,0,0,     0,1,8'hD3,1,0);
    add(1,1,0,0,     0,0,8'h00,0,0);
    run("refill_on_timeout");
`else
    // long starve mid-burst never pads; burst closes on the 4th real word
    add(1,1,2,8'h61, 1,0,8'h00,0,0);
    add(1,1,0,0,     1,1,8'h61,0,0);
    add(1,1,0,0,     0,1,8'h62,0,0);
    add(1,1,0,0,     0,0,8'h00,0,0);
    run("starve_head");

    begin
      int bad;
      bad = 0;
      for (int k = 0; k < 50; k++) begin
        @(negedge clk);
        #1;
        if (m_tvalid || fifo_rd_en || m_tuser) bad++;
      end
      n_checks++;
      if (bad != 0) begin
        n_fail++;
        $display("FAIL starve_hold: %0d active cycles during starve, expected 0", bad);
      end
    end

    add(1,1,2,8'h63, 1,0,8'h00,0,0);
    add(1,1,0,0,     1,1,8'h63,0,0);
    add(1,1,0,0,     0,1,8'h64,1,0);
    add(1,1,0,0,     0,0,8'h00,0,0);
    run("starve_tail");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
